// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock and links the chunks
// with a registered carry. Start/busy/done handshake; reports carry-out and signed overflow.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [IDXW-1:0]  idx;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             msb_carry_in;

  // Operands shift right one chunk per cycle, so the active chunk is always the low
  // CHUNK bits; results enter the accumulator from the top and land in place after NCHUNK steps.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    chunk_sum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    acc_next     = (acc >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_carry_in = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are plain flops, so they are all cleared along with the FSM.
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= BUSY;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | c_in;
            idx     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc     <= acc_next;
          carry_q <= chunk_sum[CHUNK];
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= acc_next;
            carry_out <= chunk_sum[CHUNK];
            overflow  <= chunk_sum[CHUNK] ^ msb_carry_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: a cycle-level arithmetic model checks the 32/8 instance every cycle;
// directed literal cases pin the model, and a CHUNK=WIDTH instance checks the single-chunk path.
module tb_chunked_serial_adder;

  localparam int W   = 32;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0, c_in = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] sum;

  logic         start2 = 1'b0, sub2 = 1'b0, c_in2 = 1'b0;
  logic [W-1:0] a2 = '0, b2 = '0;
  logic         busy2, done2, co2, ov2;
  logic [W-1:0] sum2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(c_in2),
    .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2), .overflow(ov2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {overflow, carry_out, sum}.
  function automatic logic [33:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         co, ov;
    if (s) begin
      res = x - y;
      co  = (x >= y);
      ov  = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
    end else begin
      r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      res = r[W-1:0];
      co  = r[W];
      ov  = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
    end
    return {ov, co, res};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Timing model: an accepted request occupies NCH busy cycles, then one done cycle.
  int           left = 0;
  logic [33:0]  pend = '0;
  logic [35:0]  expv = '0;   // {busy, done, overflow, carry_out, sum}

  always @(posedge clk) begin
    int          nl;
    logic        nd;
    logic [33:0] np;
    logic [33:0] res;
    nl  = left;
    nd  = 1'b0;
    np  = pend;
    res = expv[33:0];
    if (!rst_n) begin
      nl  = 0;
      np  = '0;
      res = '0;
    end else if (nl > 0) begin
      nl--;
      if (nl == 0) begin
        nd  = 1'b1;
        res = np;
      end
    end else if (start) begin
      nl = NCH;
      np = ref_op(a, b, c_in, sub);
    end
    left <= nl;
    pend <= np;
    expv <= {(nl > 0), nd, res};
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle", {28'h0, busy, done, overflow, carry_out, sum}, {28'h0, expv});
  end

  task automatic do_op(input bit now, input bit poke,
                       input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                       input logic [W-1:0] es, input logic eco, input logic eov, input string nm);
    int lat, nbusy;
    check({nm, "_ref"}, {30'h0, ref_op(ta, tb, tc, ts)}, {30'h0, eov, eco, es});
    if (!now) @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; start = 1'b1;
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy === 1'b1);
      start = poke && (lat == 1 || lat == 2);
      a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
    end while (done !== 1'b1 && lat < 20);
    start = 1'b0;
    check({nm, "_done_latency"}, lat, NCH + 1);
    check({nm, "_busy_cycles"}, nbusy, NCH);
    check({nm, "_result"}, {30'h0, overflow, carry_out, sum}, {30'h0, eov, eco, es});
  endtask

  task automatic count_done(input int n, input string nm);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      pulses += int'(done === 1'b1);
    end
    check(nm, pulses, 0);
  endtask

  task automatic do_wide(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts, input string nm);
    logic [33:0] e;
    int lat, nbusy;
    e = ref_op(ta, tb, tc, ts);
    @(negedge clk);
    a2 = ta; b2 = tb; c_in2 = tc; sub2 = ts; start2 = 1'b1;
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      nbusy += int'(busy2 === 1'b1);
      start2 = 1'b0;
      a2 = $urandom; b2 = $urandom;
    end while (done2 !== 1'b1 && lat < 20);
    check({nm, "_done_latency"}, lat, 2);
    check({nm, "_busy_cycles"}, nbusy, 1);
    check({nm, "_result"}, {30'h0, ov2, co2, sum2}, {30'h0, e});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_state", {28'h0, busy, done, overflow, carry_out, sum}, 64'h0);
    check("reset_state_wide", {28'h0, busy2, done2, ov2, co2, sum2}, 64'h0);
    rst_n = 1'b1;

    // Arithmetic corners with literal expectations.
    do_op(0, 0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
    do_op(0, 0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    do_op(0, 0, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_cin");
    do_op(0, 0, 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    do_op(0, 0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    do_op(0, 0, 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_cin_ignored");

    // start pulses during BUSY are ignored; exactly one done.
    do_op(0, 1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "busy_start_ignored");
    count_done(8, "extra_done_pulses");

    // Back-to-back: start held during the DONE cycle.
    do_op(0, 0, 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, "b2b_first");
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "b2b_second");
    do_op(0, 0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "pre_reset");

    // Reset asserted in the second BUSY cycle aborts the operation.
    @(negedge clk);
    a = 32'h1234; b = 32'h1; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy_reset", {28'h0, busy, done, overflow, carry_out, sum}, 64'h0);
    rst_n = 1'b1;
    count_done(8, "done_after_abort");
    do_op(0, 0, 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "after_reset");

    // Single-chunk instance.
    do_wide(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "wide_literal");
    check("wide_literal_sum", sum2, 32'h2345_6789);
    for (int i = 0; i < 20; i++)
      do_wide(pick(), pick(), 1'($urandom), 1'($urandom), "wide_rand");

    // Free-running random traffic, including start during BUSY/DONE and sporadic resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = pick();
      b     = pick();
      c_in  = 1'($urandom);
      sub   = 1'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (NCH + 3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
